p_mul_arb: RTL and testbench
============================

# p_mul_arb

Two-port arbiter and sequencer for a single shared packed multiplier (`p_mul`).
- Accepts packed multiply / carry-less multiply requests from two requesters (port A, port B).
- Selects one request round-robin, latches its operands and holds them stable on the multiplier port until it finishes.
- Returns the registered result to the winning requester only.
- Sits between the issue logic of the packed-arithmetic unit and the `p_mul` instance. Rejects malformed operations and aborts operations that stall.

## Interface
Parameters:
- WDOG_CYCLES, 40, maximum cycles `m_valid` may stay high before abort with error. Must be ≥ 34.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- a_valid / b_valid  in  1  request; held high with stable operands until matching ready
- a_ready / b_ready  out  1  one-cycle pulse: result/error for that port valid this cycle
- a_mul_l, a_mul_h, a_clmul / b_*  in  1 each  operation select; exactly one set
- a_pw / b_pw  in  5  one-hot lane width: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2
- a_crs1, a_crs2 / b_*  in  32 each  operands
- a_result / b_result  out  32  registered result; 0 when not ready
- a_error / b_error  out  1  qualifies ready: malformed op or watchdog abort
- m_valid  out  1  request to `p_mul`
- m_ready  in  1  `p_mul` finish (combinational from `p_mul`)
- m_mul_l, m_mul_h, m_clmul  out  1 each  latched op select
- m_pw  out  5  latched pack width
- m_crs1, m_crs2  out  32 each  latched operands
- m_result  in  32  `p_mul` result, sampled when m_ready=1
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - Neither valid: stay.
  - One valid: grant it.
  - Both valid: grant the port named by the priority pointer.
  - On grant: latch op fields into m_* registers and record the grant.
  - Malformed op (pw not one-hot, or {mul_l,mul_h,clmul} not one-hot): go to RESP with result 0, error 1. m_valid never asserts.
  - Otherwise go to BUSY. Clear the watchdog counter.
- BUSY: m_valid=1. m_* outputs constant. Watchdog increments each cycle.
  - Granted valid low (abort): go to IDLE, no response, result discarded even if m_ready=1 the same cycle. The priority pointer is unchanged.
  - Else m_ready=1: capture m_result and set error=0, go to RESP.
  - Else watchdog = WDOG_CYCLES-1: set result 0 and error 1, go to RESP.
- RESP: granted port ready=1 with result/error for exactly one cycle. Other port ready=0 and result 0. Pointer is set to the non-granted port, then go to IDLE.
- After seeing ready, a requester must drop valid the next cycle. Valid still high in IDLE is a new request.
- Priority pointer is updated only on completed responses, including error responses.
- Reset (any state, including mid-BUSY): state=IDLE, pointer=A. All outputs and m_* registers = 0, and m_valid falls asynchronously.

## Timing
- Grant cycle is cycle 0 (IDLE, request sampled).
- m_valid is high in cycles 1..L+1, where L = lane width (32/16/8/4/2). `p_mul` asserts m_ready in cycle L+1.
- ready pulses in cycle L+2. Latency from grant is L+2 cycles; the earliest next grant is L+3.
- Malformed op: ready+error in cycle 1.
- Watchdog: m_valid is high in cycles 1..WDOG_CYCLES, ready+error in cycle WDOG_CYCLES+1.
- Abort: m_valid is low the cycle after valid drops, so `p_mul` clears its count before any new grant.
- m_valid is low for ≥2 cycles (RESP, IDLE) between consecutive operations.
- All outputs are registered except busy, which decodes state flops.

## Test plan
- A only, pw=00001, mul_l, crs1=7, crs2=6 -> m_valid high 33 cycles, a_ready at cycle 34 with a_result=0x0000002A, a_error=0, b_ready never.
- Both valid in the same cycle after reset, pw=00100, mul_l, crs1=0x03030303, crs2=0x05050505 -> A granted first, a_result=0x0F0F0F0F at cycle 10. Then B granted at cycle 11, b_ready at cycle 21. Both hold valid again -> A next (pointer alternates).
- B with pw=00110 -> b_ready+b_error at cycle 1, b_result=0, m_valid never high. Same for mul_l=mul_h=1.
- A granted at pw=00001, a_valid dropped in cycle 10 -> m_valid low from cycle 11, no a_ready. A pending B is granted at cycle 11 and completes normally.
- Bench holds m_ready=0 (WDOG_CYCLES=40) -> a_ready+a_error at cycle 41, m_valid low from cycle 41.
- reset asserted in cycle 5 of a BUSY op -> m_valid, busy, ready all 0 immediately. After release, B request is granted first (pointer=A, A idle).

Source files
------------

// File: rtl/p_mul_arb.sv
// Two-port round-robin arbiter and sequencer for a shared packed multiplier.
// Latches the winning request and holds it on the m_* port until the multiplier finishes. Returns the result to the winner only.
module p_mul_arb #(
  parameter int WDOG_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_mul_l,
  input  logic        a_mul_h,
  input  logic        a_clmul,
  input  logic [4:0]  a_pw,
  input  logic [31:0] a_crs1,
  input  logic [31:0] a_crs2,
  output logic [31:0] a_result,
  output logic        a_error,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_mul_l,
  input  logic        b_mul_h,
  input  logic        b_clmul,
  input  logic [4:0]  b_pw,
  input  logic [31:0] b_crs1,
  input  logic [31:0] b_crs2,
  output logic [31:0] b_result,
  output logic        b_error,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_mul_l,
  output logic        m_mul_h,
  output logic        m_clmul,
  output logic [4:0]  m_pw,
  output logic [31:0] m_crs1,
  output logic [31:0] m_crs2,
  input  logic [31:0] m_result,
  output logic        busy
);

  localparam int WW = $clog2(WDOG_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_next;
  logic          grant;       // 0 = port A, 1 = port B
  logic          ptr;         // port that wins when both request
  logic [WW-1:0] wdog;

  logic          any_req, sel_b, sel_malformed, gnt_valid, wdog_done;
  logic          sel_mul_l, sel_mul_h, sel_clmul;
  logic [4:0]    sel_pw;
  logic [31:0]   sel_crs1, sel_crs2;

  logic          grant_d, resp_d, a_ready_d, b_ready_d, error_d;
  logic [31:0]   result_d;

  assign any_req   = a_valid | b_valid;
  assign sel_b     = (a_valid && b_valid) ? ptr : b_valid;
  assign sel_mul_l = sel_b ? b_mul_l : a_mul_l;
  assign sel_mul_h = sel_b ? b_mul_h : a_mul_h;
  assign sel_clmul = sel_b ? b_clmul : a_clmul;
  assign sel_pw    = sel_b ? b_pw    : a_pw;
  assign sel_crs1  = sel_b ? b_crs1  : a_crs1;
  assign sel_crs2  = sel_b ? b_crs2  : a_crs2;
  assign sel_malformed = !$onehot(sel_pw) || !$onehot({sel_mul_l, sel_mul_h, sel_clmul});
  assign gnt_valid = grant ? b_valid : a_valid;
  assign wdog_done = (wdog == WW'(WDOG_CYCLES - 1));
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (any_req) state_next = sel_malformed ? RESP : BUSY;
      // A dropped request aborts even if the multiplier finishes this cycle.
      BUSY: begin
        if (!gnt_valid)                 state_next = IDLE;
        else if (m_ready || wdog_done)  state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_d  = (state == IDLE) ? sel_b : grant;
    result_d = '0;
    error_d  = 1'b0;
    if (state == IDLE) begin
      error_d = 1'b1;
    end else if (state == BUSY) begin
      if (m_ready) result_d = m_result;
      else         error_d  = 1'b1;
    end
    resp_d    = (state_next == RESP) && (state != RESP);
    a_ready_d = resp_d && !grant_d;
    b_ready_d = resp_d &&  grant_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant    <= 1'b0;
      ptr      <= 1'b0;
      wdog     <= '0;
      a_ready  <= 1'b0;
      a_result <= '0;
      a_error  <= 1'b0;
      b_ready  <= 1'b0;
      b_result <= '0;
      b_error  <= 1'b0;
      m_valid  <= 1'b0;
      m_mul_l  <= 1'b0;
      m_mul_h  <= 1'b0;
      m_clmul  <= 1'b0;
      m_pw     <= '0;
      m_crs1   <= '0;
      m_crs2   <= '0;
    end else begin
      a_ready  <= a_ready_d;
      a_result <= a_ready_d ? result_d : '0;
      a_error  <= a_ready_d & error_d;
      b_ready  <= b_ready_d;
      b_result <= b_ready_d ? result_d : '0;
      b_error  <= b_ready_d & error_d;
      m_valid  <= (state_next == BUSY);
      wdog     <= (state == BUSY) ? wdog + WW'(1) : '0;
      if (state == IDLE && any_req) begin
        grant   <= sel_b;
        m_mul_l <= sel_mul_l;
        m_mul_h <= sel_mul_h;
        m_clmul <= sel_clmul;
        m_pw    <= sel_pw;
        m_crs1  <= sel_crs1;
        m_crs2  <= sel_crs2;
      end
      // Pointer moves only on a delivered response, never on abort.
      if (state == RESP) ptr <= ~grant;
    end
  end

endmodule

// File: tb/tb_p_mul_arb.sv
// Scoreboard bench for p_mul_arb: directed requests push expected responses,
// a negedge monitor pops and compares them; the bench also plays the p_mul role.
module tb_p_mul_arb;

  localparam int WDOG = 40;
  localparam logic [2:0] OP_L = 3'b100, OP_H = 3'b010, OP_C = 3'b001;

  logic        clock = 1'b0, reset = 1'b1;
  logic        a_valid = 0, a_mul_l = 0, a_mul_h = 0, a_clmul = 0;
  logic [4:0]  a_pw = 0;
  logic [31:0] a_crs1 = 0, a_crs2 = 0;
  logic        b_valid = 0, b_mul_l = 0, b_mul_h = 0, b_clmul = 0;
  logic [4:0]  b_pw = 0;
  logic [31:0] b_crs1 = 0, b_crs2 = 0;
  logic        a_ready, a_error, b_ready, b_error;
  logic [31:0] a_result, b_result;
  logic        m_valid, m_ready, m_mul_l, m_mul_h, m_clmul, busy;
  logic [4:0]  m_pw;
  logic [31:0] m_crs1, m_crs2, m_result;
  logic        stall = 1'b0;

  int cyc = 0, mcnt = 0, mv_run = 0;
  int errors = 0, checks = 0;

  typedef struct {
    logic        port;
    logic [31:0] result;
    logic        error;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  int   mv_q[$];

  p_mul_arb #(.WDOG_CYCLES(WDOG)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_mul_l(a_mul_l), .a_mul_h(a_mul_h),
    .a_clmul(a_clmul), .a_pw(a_pw), .a_crs1(a_crs1), .a_crs2(a_crs2),
    .a_result(a_result), .a_error(a_error),
    .b_valid(b_valid), .b_ready(b_ready), .b_mul_l(b_mul_l), .b_mul_h(b_mul_h),
    .b_clmul(b_clmul), .b_pw(b_pw), .b_crs1(b_crs1), .b_crs2(b_crs2),
    .b_result(b_result), .b_error(b_error),
    .m_valid(m_valid), .m_ready(m_ready), .m_mul_l(m_mul_l), .m_mul_h(m_mul_h),
    .m_clmul(m_clmul), .m_pw(m_pw), .m_crs1(m_crs1), .m_crs2(m_crs2),
    .m_result(m_result), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lane_w(input logic [4:0] pw);
    if (pw[0]) return 32;
    if (pw[1]) return 16;
    if (pw[2]) return 8;
    if (pw[3]) return 4;
    return 2;
  endfunction

  // Behavioural packed multiplier standing in for p_mul.
  function automatic logic [31:0] pmul(input logic l, h, c, input logic [4:0] pw,
                                       input logic [31:0] x, y);
    int w;
    logic [63:0] mask, a, b, p;
    logic [31:0] r;
    w = lane_w(pw);
    mask = (64'd1 << w) - 64'd1;
    r = '0;
    for (int i = 0; i < 32 / w; i++) begin
      a = ({32'd0, x} >> (i * w)) & mask;
      b = ({32'd0, y} >> (i * w)) & mask;
      if (c) begin
        p = '0;
        for (int j = 0; j < w; j++) if (b[j]) p = p ^ (a << j);
      end else begin
        p = a * b;
      end
      if (h) p = p >> w;
      r = r | 32'((p & mask) << (i * w));
    end
    return r;
  endfunction

  always @(posedge clock) mcnt <= m_valid ? mcnt + 1 : 0;
  assign m_ready  = m_valid && !stall && (mcnt == lane_w(m_pw));
  assign m_result = pmul(m_mul_l, m_mul_h, m_clmul, m_pw, m_crs1, m_crs2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_resp(input logic port, input logic [31:0] res, input logic err,
                             input int at);
    exp_t e;
    e.port = port; e.result = res; e.error = err; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [4:0] pw, input logic [31:0] x, y);
    {a_mul_l, a_mul_h, a_clmul} = op;
    a_pw = pw; a_crs1 = x; a_crs2 = y; a_valid = 1'b1;
  endtask

  task automatic drive_b(input logic [2:0] op, input logic [4:0] pw, input logic [31:0] x, y);
    {b_mul_l, b_mul_h, b_clmul} = op;
    b_pw = pw; b_crs1 = x; b_crs2 = y; b_valid = 1'b1;
  endtask

  // Step cycles, dropping each valid the cycle after its ready, until both are low.
  task automatic run(input int budget);
    int n;
    logic sa, sb;
    n = 0;
    while ((a_valid || b_valid) && n < budget) begin
      @(negedge clock);
      sa = a_ready; sb = b_ready;
      @(posedge clock); #1;
      if (sa) a_valid = 1'b0;
      if (sb) b_valid = 1'b0;
      n++;
    end
    checks++;
    if (a_valid || b_valid) begin
      errors++;
      $display("FAIL run_timeout: no ready within %0d cycles (cycle %0d)", budget, cyc);
      a_valid = 1'b0; b_valid = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Response monitor and m_valid burst-length monitor.
  always @(negedge clock) begin
    exp_t e;
    if (a_ready || b_ready) begin
      check("single_ready", 32'(a_ready & b_ready), 32'd0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: got a=%0b b=%0b expected none (cycle %0d)",
                 a_ready, b_ready, cyc);
      end else begin
        e = exp_q.pop_front();
        check("resp_port",   32'(b_ready), 32'(e.port));
        check("resp_result", e.port ? b_result : a_result, e.result);
        check("resp_error",  32'(e.port ? b_error : a_error), 32'(e.error));
        check("resp_cycle",  32'(cyc), 32'(e.cyc));
        check("other_result_zero", e.port ? a_result : b_result, 32'd0);
      end
    end
    if (m_valid) begin
      mv_run++;
    end else if (mv_run > 0) begin
      if (mv_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_m_valid: got burst %0d expected none (cycle %0d)", mv_run, cyc);
      end else begin
        check("m_valid_len", 32'(mv_run), 32'(mv_q.pop_front()));
      end
      mv_run = 0;
    end
  end

  initial begin
    int n;
    #12;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_ready",   32'({a_ready, b_ready, a_error, b_error}), 32'd0);
    check("rst_m_regs",  m_crs1 | m_crs2 | 32'(m_pw), 32'd0);
    @(posedge clock); #1; reset = 1'b0;
    step(1);

    // A alone, 32-bit lane: 7*6.
    n = cyc;
    drive_a(OP_L, 5'b00001, 32'd7, 32'd6);
    expect_resp(1'b0, 32'h0000002A, 1'b0, n + 34); mv_q.push_back(33);
    run(100);

    // Fresh reset: both request together, A wins, then B, then pointer back to A.
    reset = 1'b1; step(1); reset = 1'b0; step(1);
    n = cyc;
    drive_a(OP_L, 5'b00100, 32'h03030303, 32'h05050505);
    drive_b(OP_L, 5'b00100, 32'h03030303, 32'h05050505);
    expect_resp(1'b0, 32'h0F0F0F0F, 1'b0, n + 10); mv_q.push_back(9);
    expect_resp(1'b1, 32'h0F0F0F0F, 1'b0, n + 21); mv_q.push_back(9);
    run(100);
    n = cyc;
    drive_a(OP_H, 5'b00001, 32'h00010000, 32'h00010000);
    drive_b(OP_C, 5'b00001, 32'd3, 32'd3);
    expect_resp(1'b0, 32'h00000001, 1'b0, n + 34); mv_q.push_back(33);
    expect_resp(1'b1, 32'h00000005, 1'b0, n + 69); mv_q.push_back(33);
    run(200);

    // Malformed requests: bad width on B, two op selects on A.
    n = cyc;
    drive_b(OP_L, 5'b00110, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expect_resp(1'b1, 32'd0, 1'b1, n + 1);
    run(20);
    n = cyc;
    drive_a(OP_L | OP_H, 5'b00001, 32'd9, 32'd9);
    expect_resp(1'b0, 32'd0, 1'b1, n + 1);
    run(20);

    // Abort: A drops valid in cycle 10, pending B is granted in cycle 11.
    n = cyc;
    drive_a(OP_L, 5'b00001, 32'd100, 32'd200);
    mv_q.push_back(10);
    step(2);
    drive_b(OP_L, 5'b00010, 32'h00030004, 32'h00050006);
    expect_resp(1'b1, 32'h000F0018, 1'b0, n + 29); mv_q.push_back(17);
    step(8);
    check("abort_at_cycle10", 32'(cyc - n), 32'd10);
    a_valid = 1'b0;
    run(100);

    // Watchdog: p_mul never finishes.
    stall = 1'b1;
    n = cyc;
    drive_a(OP_L, 5'b00001, 32'd7, 32'd6);
    expect_resp(1'b0, 32'd0, 1'b1, n + WDOG + 1); mv_q.push_back(WDOG);
    run(100);
    stall = 1'b0;

    // Reset in cycle 5 of a BUSY op, then B alone is served.
    drive_a(OP_L, 5'b00001, 32'd5, 32'd5);
    mv_q.push_back(4);
    step(5);
    reset = 1'b1;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_busy",    32'(busy), 32'd0);
    check("midrst_ready",   32'({a_ready, b_ready}), 32'd0);
    a_valid = 1'b0;
    step(1);
    reset = 1'b0;
    n = cyc;
    drive_b(OP_L, 5'b00001, 32'h0000FFFF, 32'h0000FFFF);
    expect_resp(1'b1, 32'hFFFE0001, 1'b0, n + 34); mv_q.push_back(33);
    run(100);

    step(3);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("mv_q_drained",  32'(mv_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
